// File: rtl/tmr_pkg.sv
// Shared types for the TMR fault scrubber.
//   state_t : scrubber FSM state encoding (plain localparams, legacy-compatible)
//   lane_t  : replica lane index, 0 = none, 1..3 = counter_1..counter_3
//   class_t : per-cycle classification of the three replicas
package tmr_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SUSPECT = 3'd1;
  localparam state_t ST_RESYNC  = 3'd2;
  localparam state_t ST_VERIFY  = 3'd3;
  localparam state_t ST_LOCKOUT = 3'd4;

  typedef logic [1:0] lane_t;
  localparam lane_t LANE_NONE = 2'd0;
  localparam lane_t LANE_1    = 2'd1;
  localparam lane_t LANE_2    = 2'd2;
  localparam lane_t LANE_3    = 2'd3;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_TRIPLE = 2'd2
  } class_t;

  // Lane index to load-strobe bit; LANE_NONE gives no strobe at all.
  function automatic logic [2:0] lane_onehot(input lane_t lane);
    logic [2:0] oh;
    oh = 3'b000;
    case (lane)
      LANE_1:  oh = 3'b001;
      LANE_2:  oh = 3'b010;
      LANE_3:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/tmr_voter3.sv
// Combinational three-way voter.
//   a, b, c : replica values
//   vote    : bitwise majority of a, b, c
//   cls     : NONE (all equal), SINGLE (exactly one odd lane), TRIPLE (all differ)
//   lane    : odd lane for SINGLE, LANE_NONE otherwise
module tmr_voter3
  import tmr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] vote,
  output class_t           cls,
  output lane_t            lane
);

  logic eq_ab, eq_ac, eq_bc;

  always_comb begin
    vote  = (a & b) | (a & c) | (b & c);
    eq_ab = (a == b);
    eq_ac = (a == c);
    eq_bc = (b == c);
    cls   = CLS_TRIPLE;
    lane  = LANE_NONE;
    // Two equal pairs imply all three equal, so test that case first.
    if (eq_ab && eq_bc) begin
      cls = CLS_NONE;
    end else if (eq_ab) begin
      cls  = CLS_SINGLE;
      lane = LANE_3;
    end else if (eq_ac) begin
      cls  = CLS_SINGLE;
      lane = LANE_2;
    end else if (eq_bc) begin
      cls  = CLS_SINGLE;
      lane = LANE_1;
    end
  end

endmodule

// File: rtl/tmr_fault_scrubber.sv
// TMR fault scrubber: votes the three replica counters, locates a lone bad
// lane, repairs it with a one-cycle load strobe once it has been wrong for
// PERSIST cycles, and falls into a sticky lockout when repair is impossible.
//   clk, rst         : clock, asynchronous active-low reset
//   enable           : counters advance this cycle
//   q_1, q_2, q_3    : replica values
//   clear_lockout    : pulse to leave lockout
//   q_voted          : registered majority value
//   fault/fault_lane : registered disagreement flag / odd lane
//   resync_load      : one-hot load strobe to counter_1..3
//   resync_value     : value to load, 0 when no strobe
//   fault_count      : saturating count of strobes issued
//   lockout          : sticky uncorrectable flag
//
// state   | meaning
// IDLE    | replicas agree, nothing pending
// SUSPECT | one lane disagrees, counting persistence
// RESYNC  | load strobe driven to the bad lane this cycle
// VERIFY  | load has landed, check the repair took
// LOCKOUT | uncorrectable, waits for clear_lockout or reset
module tmr_fault_scrubber
  import tmr_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PERSIST   = 2,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic             clear_lockout,
  output logic [WIDTH-1:0] q_voted,
  output logic             fault,
  output logic [1:0]       fault_lane,
  output logic [2:0]       resync_load,
  output logic [WIDTH-1:0] resync_value,
  output logic [CNT_W-1:0] fault_count,
  output logic             lockout
);

  localparam int P_W = $clog2(PERSIST + 1);
  localparam int R_W = $clog2(MAX_RETRY + 1);
  localparam logic [P_W-1:0] PERSIST_C = P_W'(PERSIST);
  localparam logic [R_W-1:0] RETRY_C   = R_W'(MAX_RETRY);

  logic [WIDTH-1:0] vote;
  class_t           cls;
  lane_t            cls_lane;

  state_t           state_q, state_d;
  lane_t            lane_q, lane_d;
  logic [P_W-1:0]   persist_q, persist_d, persist_inc;
  logic [R_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0] fault_count_q, fault_count_d;
  logic [WIDTH-1:0] q_voted_q, q_voted_d;
  logic             fault_q, fault_d;
  lane_t            fault_lane_q, fault_lane_d;

  tmr_voter3 #(.WIDTH(WIDTH)) u_voter (
    .a    (q_1),
    .b    (q_2),
    .c    (q_3),
    .vote (vote),
    .cls  (cls),
    .lane (cls_lane)
  );

  always_comb begin
    q_voted_d    = vote;
    fault_d      = (cls != CLS_NONE);
    fault_lane_d = cls_lane;
  end

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    persist_d     = persist_q;
    retry_d       = retry_q;
    fault_count_d = fault_count_q;
    persist_inc   = persist_q + P_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (cls == CLS_SINGLE) begin
          lane_d    = cls_lane;
          persist_d = P_W'(1);
          state_d   = (PERSIST == 1) ? ST_RESYNC : ST_SUSPECT;
        end else if (cls == CLS_TRIPLE) begin
          state_d = ST_LOCKOUT;
        end
      end

      ST_SUSPECT: begin
        if (cls == CLS_NONE) begin
          // Transient upset that healed itself: no repair, no count.
          state_d   = ST_IDLE;
          persist_d = '0;
        end else if (cls == CLS_TRIPLE) begin
          state_d = ST_LOCKOUT;
        end else if (cls_lane == lane_q) begin
          persist_d = persist_inc;
          if (persist_inc == PERSIST_C) state_d = ST_RESYNC;
        end else begin
          // A different lane is now the odd one: persistence starts over.
          lane_d    = cls_lane;
          persist_d = P_W'(1);
          if (PERSIST == 1) state_d = ST_RESYNC;
        end
      end

      ST_RESYNC: begin
        retry_d   = retry_q + R_W'(1);
        persist_d = '0;
        if (fault_count_q != '1) fault_count_d = fault_count_q + CNT_W'(1);
        state_d   = ST_VERIFY;
      end

      ST_VERIFY: begin
        if (cls == CLS_NONE) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else if (cls == CLS_SINGLE && retry_q < RETRY_C) begin
          lane_d  = cls_lane;
          state_d = ST_RESYNC;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end

      ST_LOCKOUT: begin
        if (clear_lockout) begin
          state_d   = ST_IDLE;
          lane_d    = LANE_NONE;
          persist_d = '0;
          retry_d   = '0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        lane_d    = LANE_NONE;
        persist_d = '0;
        retry_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      lane_q        <= LANE_NONE;
      persist_q     <= '0;
      retry_q       <= '0;
      fault_count_q <= '0;
      q_voted_q     <= '0;
      fault_q       <= 1'b0;
      fault_lane_q  <= LANE_NONE;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      persist_q     <= persist_d;
      retry_q       <= retry_d;
      fault_count_q <= fault_count_d;
      q_voted_q     <= q_voted_d;
      fault_q       <= fault_d;
      fault_lane_q  <= fault_lane_d;
    end
  end

  // The strobe is decoded straight from state so an async reset kills it at
  // once. The value uses this cycle's vote plus enable so the repaired lane
  // lands on the same count the good lanes step to at the same edge.
  always_comb begin
    resync_load  = 3'b000;
    resync_value = '0;
    if (state_q == ST_RESYNC) begin
      resync_load  = lane_onehot(lane_q);
      resync_value = vote + WIDTH'(enable);
    end
  end

  assign q_voted     = q_voted_q;
  assign fault       = fault_q;
  assign fault_lane  = fault_lane_q;
  assign fault_count = fault_count_q;
  assign lockout     = (state_q == ST_LOCKOUT);

endmodule

// File: tb/tb_tmr_fault_scrubber.sv
// Directed, table-driven bench for tmr_fault_scrubber. Each row is one clock
// cycle: inputs are applied just after the falling edge and outputs are
// sampled 1 time unit later, so registered outputs show the previous row's
// inputs and the strobe shows the state reached at the last rising edge.
module tb_tmr_fault_scrubber;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] q_1, q_2, q_3;
  logic       clear_lockout;
  logic [3:0] q_voted;
  logic       fault;
  logic [1:0] fault_lane;
  logic [2:0] resync_load;
  logic [3:0] resync_value;
  logic [7:0] fault_count;
  logic       lockout;

  int total = 0;
  int bad   = 0;

  tmr_fault_scrubber #(
    .WIDTH(4), .PERSIST(2), .MAX_RETRY(3), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .q_1           (q_1),
    .q_2           (q_2),
    .q_3           (q_3),
    .clear_lockout (clear_lockout),
    .q_voted       (q_voted),
    .fault         (fault),
    .fault_lane    (fault_lane),
    .resync_load   (resync_load),
    .resync_value  (resync_value),
    .fault_count   (fault_count),
    .lockout       (lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q1, q2, q3;
    logic       en, clr;
    logic [3:0] v;
    logic       f;
    logic [1:0] l;
    logic [2:0] ld;
    logic [3:0] val;
    logic       lk;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] q1, q2, q3, input logic en, clr,
                              input logic [3:0] v, input logic f, input logic [1:0] l,
                              input logic [2:0] ld, input logic [3:0] val,
                              input logic lk, input logic [7:0] cnt);
    vec_t r;
    r.q1 = q1; r.q2 = q2; r.q3 = q3; r.en = en; r.clr = clr;
    r.v = v; r.f = f; r.l = l; r.ld = ld; r.val = val; r.lk = lk; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_voted"}, -1, 32'(q_voted), 32'd0);
    chk({tag, "_fault"}, -1, 32'(fault), 32'd0);
    chk({tag, "_lane"},  -1, 32'(fault_lane), 32'd0);
    chk({tag, "_load"},  -1, 32'(resync_load), 32'd0);
    chk({tag, "_value"}, -1, 32'(resync_value), 32'd0);
    chk({tag, "_count"}, -1, 32'(fault_count), 32'd0);
    chk({tag, "_lock"},  -1, 32'(lockout), 32'd0);
  endtask

  task automatic apply(input logic [3:0] a, b, c, input logic en, clr);
    @(negedge clk);
    q_1 = a; q_2 = b; q_3 = c; enable = en; clear_lockout = clr;
    #1;
  endtask

  task automatic run_row(input vec_t r, input int idx);
    apply(r.q1, r.q2, r.q3, r.en, r.clr);
    chk("voted", idx, 32'(q_voted), 32'(r.v));
    chk("fault", idx, 32'(fault), 32'(r.f));
    chk("lane",  idx, 32'(fault_lane), 32'(r.l));
    chk("load",  idx, 32'(resync_load), 32'(r.ld));
    chk("value", idx, 32'(resync_value), 32'(r.val));
    chk("lock",  idx, 32'(lockout), 32'(r.lk));
    chk("count", idx, 32'(fault_count), 32'(r.cnt));
    if (resync_load != 3'b000 && resync_load != 3'b001 &&
        resync_load != 3'b010 && resync_load != 3'b100) begin
      chk("onehot", idx, 32'(resync_load), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; clear_lockout = 1'b0;
    q_1 = 4'h0; q_2 = 4'h0; q_3 = 4'h0;

    // 1: replicas agree and count 0..9
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(4'(i), 4'(i), 4'(i), 1'b1, 1'b0,
                        (i == 0) ? 4'd0 : 4'(i - 1), 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd0));
    // 2: one-cycle upset on lane 2, no strobe
    vecs.push_back(mk(4'h5, 4'h5, 4'h5, 1'b1, 1'b0, 4'h9, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd0));
    vecs.push_back(mk(4'h5, 4'hA, 4'h5, 1'b1, 1'b0, 4'h5, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd0));
    vecs.push_back(mk(4'h5, 4'h5, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1, 2'd2, 3'b000, 4'h0, 1'b0, 8'd0));
    vecs.push_back(mk(4'h5, 4'h5, 4'h5, 1'b1, 1'b0, 4'h5, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd0));
    // 3: lane 2 stuck, vote 7 with enable -> load 8, repair holds
    vecs.push_back(mk(4'h7, 4'h7, 4'h7, 1'b1, 1'b0, 4'h5, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd0));
    vecs.push_back(mk(4'h7, 4'h2, 4'h7, 1'b1, 1'b0, 4'h7, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd0));
    vecs.push_back(mk(4'h7, 4'h2, 4'h7, 1'b1, 1'b0, 4'h7, 1'b1, 2'd2, 3'b000, 4'h0, 1'b0, 8'd0));
    vecs.push_back(mk(4'h7, 4'h2, 4'h7, 1'b1, 1'b0, 4'h7, 1'b1, 2'd2, 3'b010, 4'h8, 1'b0, 8'd0));
    vecs.push_back(mk(4'h8, 4'h8, 4'h8, 1'b1, 1'b0, 4'h7, 1'b1, 2'd2, 3'b000, 4'h0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h8, 4'h8, 4'h8, 1'b1, 1'b0, 4'h8, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd1));
    // 4: vote F with enable, lane 3 stuck -> load value wraps to 0
    vecs.push_back(mk(4'hF, 4'hF, 4'h3, 1'b1, 1'b0, 4'h8, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd1));
    vecs.push_back(mk(4'hF, 4'hF, 4'h3, 1'b1, 1'b0, 4'hF, 1'b1, 2'd3, 3'b000, 4'h0, 1'b0, 8'd1));
    vecs.push_back(mk(4'hF, 4'hF, 4'h3, 1'b1, 1'b0, 4'hF, 1'b1, 2'd3, 3'b100, 4'h0, 1'b0, 8'd1));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 1'b1, 2'd3, 3'b000, 4'h0, 1'b0, 8'd2));
    vecs.push_back(mk(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd2));
    // 5: lane 1 stuck (enable low), three strobes then lockout, then clear
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd2));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b000, 4'h0, 1'b0, 8'd2));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b001, 4'h4, 1'b0, 8'd2));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b000, 4'h0, 1'b0, 8'd3));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b001, 4'h4, 1'b0, 8'd3));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b000, 4'h0, 1'b0, 8'd4));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b001, 4'h4, 1'b0, 8'd4));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b000, 4'h0, 1'b0, 8'd5));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b000, 4'h0, 1'b1, 8'd5));
    vecs.push_back(mk(4'hC, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b1, 2'd1, 3'b000, 4'h0, 1'b1, 8'd5));
    vecs.push_back(mk(4'h4, 4'h4, 4'h4, 1'b0, 1'b1, 4'h4, 1'b1, 2'd1, 3'b000, 4'h0, 1'b1, 8'd5));
    vecs.push_back(mk(4'h4, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd5));
    // odd lane moves while suspect: persistence restarts, no strobe
    vecs.push_back(mk(4'h5, 4'h5, 4'h9, 1'b1, 1'b0, 4'h4, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd5));
    vecs.push_back(mk(4'h9, 4'h5, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1, 2'd3, 3'b000, 4'h0, 1'b0, 8'd5));
    vecs.push_back(mk(4'h5, 4'h5, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1, 2'd1, 3'b000, 4'h0, 1'b0, 8'd5));
    vecs.push_back(mk(4'h5, 4'h5, 4'h5, 1'b1, 1'b1, 4'h5, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd5));
    // 6: all lanes differ -> immediate lockout, then clear
    vecs.push_back(mk(4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 4'h5, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd5));
    vecs.push_back(mk(4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1, 2'd0, 3'b000, 4'h0, 1'b1, 8'd5));
    vecs.push_back(mk(4'h5, 4'h5, 4'h5, 1'b1, 1'b1, 4'h3, 1'b1, 2'd0, 3'b000, 4'h0, 1'b1, 8'd5));
    vecs.push_back(mk(4'h5, 4'h5, 4'h5, 1'b1, 1'b0, 4'h5, 1'b0, 2'd0, 3'b000, 4'h0, 1'b0, 8'd5));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_row(vecs[i], i);

    // reset asserted during the RESYNC cycle kills the strobe immediately
    apply(4'h7, 4'h7, 4'h7, 1'b1, 1'b0);
    apply(4'h7, 4'h7, 4'h3, 1'b1, 1'b0);
    apply(4'h7, 4'h7, 4'h3, 1'b1, 1'b0);
    apply(4'h7, 4'h7, 4'h3, 1'b1, 1'b0);
    chk("mid_load",  0, 32'(resync_load), 32'h4);
    chk("mid_value", 0, 32'(resync_value), 32'h8);
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    apply(4'h7, 4'h7, 4'h7, 1'b1, 1'b0);
    chk("post_load",  0, 32'(resync_load), 32'h0);
    chk("post_count", 0, 32'(fault_count), 32'h0);
    chk("post_lock",  0, 32'(lockout), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
